xmm_muldiv_unit: RTL and testbench

Iterative signed q15.48 fixed-point multiply/divide unit that sits directly downstream of the XMM register file read ports and upstream of its write port. It consumes two 64-bit operands plus a destination register index and, after a fixed latency, produces a saturated 64-bit result as a one-cycle write strobe. That strobe drives the register file's `should_write`/`write_addr`/`write_data` inputs directly.

---
 rtl/xmm_muldiv_unit.sv | 219 +++++++++++++++++++++
 tb/tb_xmm_muldiv_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/xmm_muldiv_unit.sv
// Iterative signed q15.48 multiply/divide unit feeding the XMM register file write port.
// One operation in flight; fixed 67-cycle latency from accept to the one-cycle write strobe.
module xmm_muldiv_unit #(
    parameter int WIDTH     = 64,
    parameter int FRAC_BITS = 48
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [4:0]       dst_addr,
    output logic             ready,
    output logic             should_write,
    output logic [4:0]       write_addr,
    output logic [WIDTH-1:0] write_data,
    output logic             overflow,
    output logic             div_zero
);

    localparam int PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_ITER  = 3'd2,
        S_FIX   = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [4:0]       r_dst;
    logic             r_sign;
    logic             r_dz;
    logic             r_dov;
    logic [5:0]       r_cnt;
    logic [WIDTH-1:0] r_mb;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_rem;
    logic [PW-1:0]    r_acc;

    logic             r_ready;
    logic             r_should_write;
    logic [4:0]       r_write_addr;
    logic [WIDTH-1:0] r_write_data;
    logic             r_overflow;
    logic             r_div_zero;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_a_ext;
    logic [PW-1:0]    w_b_ext;
    logic             w_div_ovf;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_rem_ge;
    logic [WIDTH-1:0] w_rem_diff;
    logic [PW-1:0]    w_mul_acc;
    logic [WIDTH-1:0] w_mag;
    logic             w_big;
    logic [WIDTH-1:0] w_res;
    logic             w_res_ovf;

    assign ready        = r_ready;
    assign should_write = r_should_write;
    assign write_addr   = r_write_addr;
    assign write_data   = r_write_data;
    assign overflow     = r_overflow;
    assign div_zero     = r_div_zero;

    // Operand magnitudes and the DIV overflow test |a| >= |b|<<15, scaled by 2^48 to stay exact.
    always_comb begin
        w_a_mag   = r_a[WIDTH-1] ? (~r_a + WIDTH'(1)) : r_a;
        w_b_mag   = r_b[WIDTH-1] ? (~r_b + WIDTH'(1)) : r_b;
        w_a_ext   = {{WIDTH{1'b0}}, w_a_mag} << FRAC_BITS;
        w_b_ext   = {{WIDTH{1'b0}}, w_b_mag} << (WIDTH - 1);
        w_div_ovf = (w_a_ext >= w_b_ext);
    end

    // One step of shift-add multiply and of restoring division.
    always_comb begin
        w_rem_sh   = {r_rem, r_shift[WIDTH-1]};
        w_rem_ge   = (w_rem_sh >= {1'b0, r_mb});
        w_rem_diff = w_rem_sh[WIDTH-1:0] - r_mb;
        if (r_shift[WIDTH-1]) begin
            w_mul_acc = {r_acc[PW-2:0], 1'b0} + {{WIDTH{1'b0}}, r_mb};
        end else begin
            w_mul_acc = {r_acc[PW-2:0], 1'b0};
        end
    end

    // Final magnitude selection, sign application and saturation.
    always_comb begin
        w_res_ovf = 1'b0;
        if (r_op) begin
            w_mag = r_acc[WIDTH-1:0];
            w_big = 1'b0;
        end else begin
            w_mag = r_acc[FRAC_BITS+WIDTH-1:FRAC_BITS];
            w_big = |r_acc[PW-1:FRAC_BITS+WIDTH];
        end
        if (r_dz) begin
            if (r_a == {WIDTH{1'b0}}) begin
                w_res = {WIDTH{1'b0}};
            end else if (r_a[WIDTH-1]) begin
                w_res = SAT_NEG;
            end else begin
                w_res = SAT_POS;
            end
        end else if (r_dov || w_big || (!r_sign && w_mag[WIDTH-1]) || (r_sign && (w_mag > SAT_NEG))) begin
            w_res_ovf = 1'b1;
            w_res     = r_sign ? SAT_NEG : SAT_POS;
        end else begin
            // Negating a zero magnitude yields zero, so no negative zero escapes.
            w_res = r_sign ? (~w_mag + WIDTH'(1)) : w_mag;
        end
    end

    // Control FSM with datapath registers and registered write-port outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_op           <= 1'b0;
            r_a            <= {WIDTH{1'b0}};
            r_b            <= {WIDTH{1'b0}};
            r_dst          <= 5'd0;
            r_sign         <= 1'b0;
            r_dz           <= 1'b0;
            r_dov          <= 1'b0;
            r_cnt          <= 6'd0;
            r_mb           <= {WIDTH{1'b0}};
            r_shift        <= {WIDTH{1'b0}};
            r_rem          <= {WIDTH{1'b0}};
            r_acc          <= {PW{1'b0}};
            r_ready        <= 1'b0;
            r_should_write <= 1'b0;
            r_write_addr   <= 5'd0;
            r_write_data   <= {WIDTH{1'b0}};
            r_overflow     <= 1'b0;
            r_div_zero     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && r_ready) begin
                        r_op    <= op;
                        r_a     <= src_a;
                        r_b     <= src_b;
                        r_dst   <= dst_addr;
                        r_ready <= 1'b0;
                        r_state <= S_PREP;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_PREP: begin
                    r_sign  <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
                    r_dz    <= r_op && (r_b == {WIDTH{1'b0}});
                    r_dov   <= r_op && w_div_ovf;
                    r_mb    <= w_b_mag;
                    r_acc   <= {PW{1'b0}};
                    r_cnt   <= 6'd63;
                    // DIV starts with the dividend's top bits as remainder and shifts in the rest.
                    if (r_op) begin
                        r_rem   <= w_a_mag >> (WIDTH - FRAC_BITS);
                        r_shift <= w_a_mag << FRAC_BITS;
                    end else begin
                        r_rem   <= {WIDTH{1'b0}};
                        r_shift <= w_a_mag;
                    end
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    if (r_op) begin
                        r_rem <= w_rem_ge ? w_rem_diff : w_rem_sh[WIDTH-1:0];
                        r_acc <= {r_acc[PW-2:0], w_rem_ge};
                    end else begin
                        r_acc <= w_mul_acc;
                    end
                    r_shift <= r_shift << 1;
                    if (r_cnt == 6'd0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt   <= r_cnt - 6'd1;
                        r_state <= S_ITER;
                    end
                end
                S_FIX: begin
                    r_should_write <= 1'b1;
                    r_write_addr   <= r_dst;
                    r_write_data   <= w_res;
                    r_overflow     <= w_res_ovf;
                    r_div_zero     <= r_dz;
                    r_state        <= S_WRITE;
                end
                S_WRITE: begin
                    r_should_write <= 1'b0;
                    r_write_addr   <= 5'd0;
                    r_write_data   <= {WIDTH{1'b0}};
                    r_overflow     <= 1'b0;
                    r_div_zero     <= 1'b0;
                    r_ready        <= 1'b1;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_should_write <= 1'b0;
                    r_ready        <= 1'b0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xmm_muldiv_unit.sv
// Scoreboard bench for xmm_muldiv_unit: directed vectors plus randomized operands
// checked against a plain-arithmetic q15.48 reference model.
module tb_xmm_muldiv_unit;

    localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONE  = 64'h0001_0000_0000_0000;
    localparam logic [63:0] TWO  = 64'h0002_0000_0000_0000;
    localparam logic [63:0] THR  = 64'h0003_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        op;
    logic [63:0] src_a;
    logic [63:0] src_b;
    logic [4:0]  dst_addr;
    logic        ready;
    logic        should_write;
    logic [4:0]  write_addr;
    logic [63:0] write_data;
    logic        overflow;
    logic        div_zero;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  addr;
        logic        ovf;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   last_acc = 0;
    logic saw_ready;

    xmm_muldiv_unit dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .dst_addr(dst_addr),
        .ready(ready), .should_write(should_write), .write_addr(write_addr),
        .write_data(write_data), .overflow(overflow), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact magnitudes with wide integer arithmetic, truncation toward zero, then saturation.
    function automatic void model(input logic o, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic ovf, output logic dz);
        logic [63:0]  ua, ub;
        logic [127:0] ma, mb, mag;
        logic         neg;
        ua  = a[63] ? -a : a;
        ub  = b[63] ? -b : b;
        ma  = {64'd0, ua};
        mb  = {64'd0, ub};
        neg = a[63] ^ b[63];
        r   = 64'd0;
        ovf = 1'b0;
        dz  = 1'b0;
        if (o && b == 64'd0) begin
            dz = 1'b1;
            if (a == 64'd0) r = 64'd0;
            else if (a[63]) r = MINV;
            else r = MAXV;
        end else begin
            if (o) begin
                mag = (ma << 48) / mb;
                ovf = (mag >= 128'h8000_0000_0000_0000);
            end else begin
                mag = (ma * mb) >> 48;
                ovf = neg ? (mag > 128'h8000_0000_0000_0000) : (mag > 128'h7FFF_FFFF_FFFF_FFFF);
            end
            if (ovf) r = neg ? MINV : MAXV;
            else r = neg ? -mag[63:0] : mag[63:0];
        end
    endfunction

    function automatic logic [63:0] rand_val();
        logic [63:0] v;
        int unsigned k;
        k = $urandom_range(0, 5);
        v = {$urandom, $urandom};
        case (k)
            0: v = v;
            1, 2: v = $signed(v) >>> $urandom_range(10, 44);
            3: v = 64'd0;
            4: v = MINV;
            default: v = $signed(v) >>> 17;
        endcase
        return v;
    endfunction

    task automatic issue(input logic o, input logic [63:0] a, input logic [63:0] b, input logic [4:0] d,
                         input logic [63:0] ed, input logic eo, input logic ez);
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 300 && !ready; i++) @(negedge clk);
        if (!ready) chk("ready_timeout", ready, 1);
        start    = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        dst_addr = d;
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_a    = {$urandom, $urandom};
        src_b    = {$urandom, $urandom};
        dst_addr = 5'($urandom);
        e.data = ed; e.addr = d; e.ovf = eo; e.dz = ez; e.cyc = cyc;
        last_acc = cyc;
        sb.push_back(e);
    endtask

    task automatic issue_model(input logic o, input logic [63:0] a, input logic [63:0] b, input logic [4:0] d);
        logic [63:0] r;
        logic        ov, z;
        model(o, a, b, r, ov, z);
        issue(o, a, b, d, r, ov, z);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (should_write) begin
            if (sb.size() == 0) begin
                chk("spurious_strobe", should_write, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("write_data", write_data, mon_e.data);
                chk("write_addr", write_addr, mon_e.addr);
                chk("overflow", overflow, mon_e.ovf);
                chk("div_zero", div_zero, mon_e.dz);
                chk("latency", cyc + 1 - mon_e.cyc, 67);
            end
        end
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 1'b0;
        src_a = 64'd0; src_b = 64'd0; dst_addr = 5'd0;
        repeat (3) @(negedge clk);
        chk("reset_ready", ready, 0);
        chk("reset_strobe", should_write, 0);
        chk("reset_data", write_data, 0);
        chk("reset_flags", {overflow, div_zero, write_addr}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", ready, 1);

        // A second start mid-operation must be ignored and ready must stay low.
        issue(1'b0, TWO, THR, 5'd5, 64'h0006_0000_0000_0000, 1'b0, 1'b0);
        while (cyc < last_acc + 10) @(negedge clk);
        start = 1'b1; op = 1'b1; src_a = THR; src_b = TWO; dst_addr = 5'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        saw_ready = 1'b0;
        while (cyc < last_acc + 66) begin
            @(negedge clk);
            if (ready) saw_ready = 1'b1;
        end
        chk("ready_busy", saw_ready, 0);
        @(negedge clk);
        chk("ready_back", ready, 1);

        issue(1'b0, 64'hFFFE_8000_0000_0000, TWO, 5'd1, 64'hFFFD_0000_0000_0000, 1'b0, 1'b0);
        issue(1'b0, 64'h4000_0000_0000_0000, TWO, 5'd2, MAXV, 1'b1, 1'b0);
        issue(1'b1, ONE, THR, 5'd3, 64'h0000_5555_5555_5555, 1'b0, 1'b0);
        issue(1'b1, -ONE, THR, 5'd4, 64'hFFFF_AAAA_AAAA_AAAB, 1'b0, 1'b0);
        issue(1'b1, -ONE, 64'd0, 5'd6, MINV, 1'b0, 1'b1);
        issue(1'b1, 64'd0, 64'd0, 5'd0, 64'd0, 1'b0, 1'b1);
        issue(1'b1, ONE, 64'd0, 5'd7, MAXV, 1'b0, 1'b1);
        issue(1'b0, -ONE, 64'd0, 5'd8, 64'd0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            issue_model(1'($urandom), rand_val(), rand_val(), 5'($urandom));
        end

        // Reset mid-operation aborts silently; the next operation completes normally.
        issue(1'b0, TWO, THR, 5'd10, 64'h0006_0000_0000_0000, 1'b0, 1'b0);
        while (cyc < last_acc + 30) @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_ready", ready, 0);
        chk("abort_strobe", should_write, 0);
        chk("abort_data", write_data, 0);
        chk("abort_flags", {overflow, div_zero, write_addr}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", ready, 1);
        repeat (80) @(negedge clk);
        issue_model(1'b0, 64'hFFFE_8000_0000_0000, THR, 5'd11);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
